// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the control unit (master) and the data memory responder (slave).
interface data_mem_responder_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [31:0] reqAddr;
    logic [2:0]  reqFunct3;
    logic [31:0] reqWdata;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRdata;
    logic        rspErr;

    modport master (
        output reqValid, reqWrite, reqAddr, reqFunct3, reqWdata, rspReady,
        input  reqReady, rspValid, rspRdata, rspErr
    );

    modport slave (
        input  reqValid, reqWrite, reqAddr, reqFunct3, reqWdata, rspReady,
        output reqReady, rspValid, rspRdata, rspErr
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory with RISC-V byte/halfword/word lane steering and wait states.
// Define MISALIGN_TRAP_EN to reject misaligned H/W accesses with rspErr instead of masking the address.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [2:0]              r_funct3;
    logic                    r_write;
    logic [31:0]             r_wdata;
    logic [31:0]             r_rdata;
    logic                    r_err;
    logic [31:0]             r_mem [DEPTH];

    logic                    w_req_ready;
    logic                    w_rsp_valid;
    logic                    w_is_byte;
    logic                    w_is_half;
    logic                    w_err;
    logic [3:0]              w_be;
    logic [31:0]             w_wdata;
    logic [31:0]             w_word;
    logic [ADDR_WIDTH-3:0]   w_idx;
    logic                    w_unused_addr;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    assign w_unused_addr = ^bus.reqAddr[31:ADDR_WIDTH];
    assign w_is_byte     = (r_funct3 == 3'b000) || (r_funct3 == 3'b100);
    assign w_is_half     = (r_funct3 == 3'b001) || (r_funct3 == 3'b101);
    assign w_idx         = r_addr[ADDR_WIDTH-1:2];
    assign w_word        = r_mem[w_idx];

`ifdef MISALIGN_TRAP_EN
    assign w_err = (w_is_half && r_addr[0]) ||
                   (!w_is_byte && !w_is_half && (r_addr[1:0] != 2'b00));
`else
    assign w_err = 1'b0;
`endif

    // Store data is replicated across lanes; the byte enables pick the target lane(s).
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        if (w_is_byte) begin
            w_be    = 4'b0001 << r_addr[1:0];
            w_wdata = {4{r_wdata[7:0]}};
        end else if (w_is_half) begin
            w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{r_wdata[15:0]}};
        end
    end

    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = !rst;
                if (bus.reqValid)
                    w_next = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1)
                    w_next = ST_ACCESS;
            end
            ST_ACCESS: w_next = ST_RESP;
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rspReady)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && bus.reqValid)
                r_cnt <= 4'(WAIT_STATES);
            else if (r_state == ST_WAIT)
                r_cnt <= r_cnt - 4'd1;
            if (r_state == ST_ACCESS) begin
                r_rdata <= (r_write || w_err) ? 32'd0 : load_extend(w_word, r_addr[1:0], r_funct3);
                r_err   <= w_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && bus.reqValid) begin
            r_addr   <= bus.reqAddr[ADDR_WIDTH-1:0];
            r_funct3 <= bus.reqFunct3;
            r_write  <= bus.reqWrite;
            r_wdata  <= bus.reqWdata;
        end
    end

    // A reset landing on the ACCESS edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (!rst && r_state == ST_ACCESS && r_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    assign bus.reqReady = w_req_ready;
    assign bus.rspValid = w_rsp_valid;
    assign bus.rspRdata = r_rdata;
    assign bus.rspErr   = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder (WAIT_STATES=1, ADDR_WIDTH=12).
module tb_data_mem_responder;
    localparam int AW = 12;
    localparam int WS = 1;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if bus();

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [32:0] sb_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic issue(input logic w, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input string tag, output bit ok);
        int t;
        ok = 1'b0;
        @(negedge clk);
        bus.reqValid  = 1'b1;
        bus.reqWrite  = w;
        bus.reqAddr   = addr;
        bus.reqFunct3 = f3;
        bus.reqWdata  = wd;
        t = 0;
        while (!bus.reqReady && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_ready"}, 32'(bus.reqReady), 32'd1);
        if (bus.reqReady) begin
            @(posedge clk);
            sb_q.push_back({exp_err, exp_rd});
            ok = 1'b1;
        end
        @(negedge clk);
        bus.reqValid = 1'b0;
    endtask

    task automatic respond(input int hold, input string tag);
        int          lat;
        logic [32:0] e;
        lat = 0;
        while (!bus.rspValid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(1 + WS));
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 33'd0;
        check({tag, "_rdata"}, bus.rspRdata, e[31:0]);
        check({tag, "_err"}, 32'(bus.rspErr), 32'(e[32]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.rspValid), 32'd1);
            check({tag, "_hold_rdata"}, bus.rspRdata, e[31:0]);
            check({tag, "_hold_reqready"}, 32'(bus.reqReady), 32'd0);
        end
        bus.rspReady = 1'b1;
        @(negedge clk);
        bus.rspReady = 1'b0;
        check({tag, "_rspvalid_after"}, 32'(bus.rspValid), 32'd0);
        check({tag, "_reqready_after"}, 32'(bus.reqReady), 32'd1);
    endtask

    task automatic txn(input logic w, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input string tag);
        bit ok;
        issue(w, addr, f3, wd, exp_rd, exp_err, tag, ok);
        if (ok) respond(0, tag);
    endtask

    initial begin
        bit ok;
        bus.reqValid  = 1'b0;
        bus.reqWrite  = 1'b0;
        bus.reqAddr   = 32'd0;
        bus.reqFunct3 = 3'b010;
        bus.reqWdata  = 32'd0;
        bus.rspReady  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_reqready", 32'(bus.reqReady), 32'd0);
        check("rst_rspvalid", 32'(bus.rspValid), 32'd0);
        check("rst_rdata", bus.rspRdata, 32'd0);
        check("rst_err", 32'(bus.rspErr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_reqready", 32'(bus.reqReady), 32'd1);

        // Word store then load
        txn(1'b1, 32'h010, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0, "sw010");
        txn(1'b0, 32'h010, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0, "lw010");
        txn(1'b0, 32'h1010, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0, "lw_alias");

        // Lane selection and extension
        txn(1'b1, 32'h020, 3'b010, 32'h80FF7F01, 32'h0, 1'b0, "sw020");
        txn(1'b0, 32'h023, 3'b000, 32'h0, 32'hFFFFFF80, 1'b0, "lb023");
        txn(1'b0, 32'h023, 3'b100, 32'h0, 32'h00000080, 1'b0, "lbu023");
        txn(1'b0, 32'h020, 3'b000, 32'h0, 32'h00000001, 1'b0, "lb020");
        txn(1'b0, 32'h021, 3'b000, 32'h0, 32'h0000007F, 1'b0, "lb021");
        txn(1'b0, 32'h022, 3'b000, 32'h0, 32'hFFFFFFFF, 1'b0, "lb022");
        txn(1'b0, 32'h022, 3'b001, 32'h0, 32'hFFFF80FF, 1'b0, "lh022");
        txn(1'b0, 32'h022, 3'b101, 32'h0, 32'h000080FF, 1'b0, "lhu022");
        txn(1'b0, 32'h020, 3'b001, 32'h0, 32'h00007F01, 1'b0, "lh020");
        txn(1'b0, 32'h020, 3'b011, 32'h0, 32'h80FF7F01, 1'b0, "lw_f3_011");

        // Byte merge
        txn(1'b1, 32'h030, 3'b010, 32'h11223344, 32'h0, 1'b0, "sw030");
        txn(1'b1, 32'h031, 3'b000, 32'h123456AA, 32'h0, 1'b0, "sb031");
        txn(1'b0, 32'h030, 3'b010, 32'h0, 32'h1122AA44, 1'b0, "lw030");

        // Backpressure on the response
        issue(1'b0, 32'h030, 3'b010, 32'h0, 32'h1122AA44, 1'b0, "hold", ok);
        if (ok) respond(5, "hold");

        // Reset during WAIT drops the store
        txn(1'b1, 32'h040, 3'b010, 32'h0, 32'h0, 1'b0, "sw040_zero");
        issue(1'b1, 32'h040, 3'b010, 32'h55, 32'h0, 1'b0, "sw040_rst", ok);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_reqready", 32'(bus.reqReady), 32'd0);
        check("midrst_rspvalid", 32'(bus.rspValid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_rspvalid", 32'(bus.rspValid), 32'd0);
        check("postrst_reqready", 32'(bus.reqReady), 32'd1);
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        txn(1'b0, 32'h040, 3'b010, 32'h0, 32'h0, 1'b0, "lw040_after_rst");

        // Misaligned halfword store
        txn(1'b1, 32'h041, 3'b001, 32'hCAFEBEEF, 32'h0, TRAP, "sh041");
        txn(1'b0, 32'h040, 3'b010, 32'h0, TRAP ? 32'h0 : 32'h0000BEEF, 1'b0, "lw040_after_sh");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
